// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline register: load extraction, writeback source select,
// register-file write port and the 64-bit retired-instruction counter.
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [31:0] mem_pc_plus4,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_write_data,
  output logic        wb_wr_en,
  output logic        wb_valid,
  output logic [63:0] instret
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] sel_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  logic            valid_d, valid_q;
  logic            reg_write_d, reg_write_q;
  logic [4:0]      rd_d, rd_q;
  logic [XLEN-1:0] data_d, data_q;
  logic [63:0]     instret_d, instret_q;

  // Misaligned halfword/word accesses are not trapped: the low offset bits are ignored.
  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = 16'h0000;
    load_ext = mem_load_data;
    case (mem_alu_result[1:0])
      2'd0:    ld_byte = mem_load_data[7:0];
      2'd1:    ld_byte = mem_load_data[15:8];
      2'd2:    ld_byte = mem_load_data[23:16];
      default: ld_byte = mem_load_data[31:24];
    endcase
    ld_half = mem_alu_result[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    case (mem_funct3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h000000, ld_byte};
      3'b101:  load_ext = {16'h0000, ld_half};
      default: load_ext = mem_load_data;
    endcase
  end

  always_comb begin
    sel_data = mem_alu_result;
    case (mem_wb_sel)
      2'b01:   sel_data = load_ext;
      2'b10:   sel_data = mem_pc_plus4;
      default: sel_data = mem_alu_result;
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    data_d      = data_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      rd_d        = '0;
      data_d      = '0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      reg_write_d = mem_reg_write;
      rd_d        = mem_rd;
      data_d      = sel_data;
    end
    // Count the instruction as it leaves WB; a flush also moves it out.
    instret_d = instret_q + {63'd0, valid_q & (flush | ~stall)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      instret_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      instret_q   <= instret_d;
    end
  end

  assign wb_rd         = rd_q;
  assign wb_write_data = data_q;
  assign wb_valid      = valid_q;
  assign instret       = instret_q;
  assign wb_wr_en      = valid_q & reg_write_q & (rd_q != 5'd0);

endmodule
